// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
// Holds the FSM encoding, skid-buffer depth and delivered-word counter width.
package fifo_rd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int RD_CNT_W   = 16;
  localparam int OCC_W      = 2;

  // Occupancy after one edge; callers pass already-qualified push/pop.
  function automatic logic [OCC_W-1:0] occ_after(input logic [OCC_W-1:0] occ,
                                                 input logic push,
                                                 input logic pop);
    logic [OCC_W-1:0] res;
    if (push && !pop) begin
      res = occ + OCC_W'(1);
    end else if (pop && !push) begin
      res = occ - OCC_W'(1);
    end else begin
      res = occ;
    end
    return res;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO-ordered skid buffer absorbing the read latency of the LMAC FIFO.
// Entry 0 is always the head; a push while full is dropped unless a pop frees a slot.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head,
  output logic             valid
);

  localparam logic [OCC_W-1:0] FULL  = OCC_W'(SKID_DEPTH);
  localparam logic [OCC_W-1:0] ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] EMPTY = {OCC_W{1'b0}};

  logic [WIDTH-1:0] entry0_r;
  logic [WIDTH-1:0] entry1_r;
  logic [OCC_W-1:0] occ_r;
  logic             valid_r;
  logic             do_pop_s;
  logic             do_push_s;
  logic [OCC_W-1:0] occ_nxt_s;

  // Qualify handshakes against current occupancy.
  always_comb begin
    do_pop_s = pop & valid_r;
    if (occ_r == FULL) begin
      do_push_s = push & do_pop_s;
    end else begin
      do_push_s = push;
    end
    occ_nxt_s = occ_after(occ_r, do_push_s, do_pop_s);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0_r <= {WIDTH{1'b0}};
      entry1_r <= {WIDTH{1'b0}};
      occ_r    <= EMPTY;
      valid_r  <= 1'b0;
    end else begin
      occ_r   <= occ_nxt_s;
      valid_r <= (occ_nxt_s != EMPTY);
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (occ_r == EMPTY) begin
            entry0_r <= push_data;
          end else begin
            entry1_r <= push_data;
          end
        end
        2'b01: begin
          entry0_r <= entry1_r;
        end
        2'b11: begin
          // With one word held the new word becomes the head directly.
          if (occ_r == ONE) begin
            entry0_r <= push_data;
          end else begin
            entry0_r <= entry1_r;
            entry1_r <= push_data;
          end
        end
        default: begin
          entry0_r <= entry0_r;
        end
      endcase
    end
  end

  assign occ   = occ_r;
  assign head  = entry0_r;
  assign valid = valid_r;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: waits for a threshold or flush, bursts reads from the
// LMAC FIFO and presents the words downstream as a valid/ready stream.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PTR    = 4,
  parameter int THRESH = 4,
  parameter int BURST  = 16
) (
  input  logic                rdclk,
  input  logic                reset,
  output logic                rden,
  input  logic [WIDTH-1:0]    dataout,
  input  logic                rdempty,
  input  logic [PTR:0]        rdusedw,
  input  logic                flush,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RD_CNT_W-1:0] rd_cnt,
  output logic                busy
);

  localparam int             BW        = $clog2(BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(BURST);
  localparam logic [BW-1:0]  BURST_PRE = BW'(BURST - 1);
  localparam logic [PTR:0]   THRESH_W  = (PTR + 1)'(THRESH);

  state_t                state_r;
  logic                  pending_r;
  logic [BW-1:0]         burst_cnt_r;
  logic [RD_CNT_W-1:0]   rd_cnt_r;
  logic [OCC_W-1:0]      occ_s;
  logic                  pop_s;
  logic                  accept_s;
  logic                  rden_s;
  logic [OCC_W:0]        credit_s;

  // Credit check counts buffered words plus the one in flight, less the word leaving now.
  always_comb begin
    pop_s    = out_valid & out_ready;
    credit_s = {1'b0, occ_s} + {{OCC_W{1'b0}}, pending_r} - {{OCC_W{1'b0}}, pop_s};
    rden_s   = (state_r == ST_DRAIN) & ~rdempty & (credit_s < 3'd2)
             & (burst_cnt_r < BURST_MAX);
    accept_s = rden_s & ~rdempty;
  end

  // Burst FSM and per-burst read counter.
  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      burst_cnt_r <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((rdusedw >= THRESH_W) || (flush && !rdempty)) begin
            state_r     <= ST_DRAIN;
            burst_cnt_r <= {BW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (accept_s) begin
            burst_cnt_r <= burst_cnt_r + BW'(1);
          end else begin
            burst_cnt_r <= burst_cnt_r;
          end
          if ((accept_s && (burst_cnt_r == BURST_PRE)) || (burst_cnt_r == BURST_MAX)
              || (rdempty && !pending_r && !flush)) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-latency tracking and delivered-word count.
  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      pending_r <= 1'b0;
      rd_cnt_r  <= {RD_CNT_W{1'b0}};
    end else begin
      pending_r <= accept_s;
      if (pop_s) begin
        rd_cnt_r <= rd_cnt_r + RD_CNT_W'(1);
      end else begin
        rd_cnt_r <= rd_cnt_r;
      end
    end
  end

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (rdclk),
    .reset     (reset),
    .push      (pending_r),
    .push_data (dataout),
    .pop       (out_ready),
    .occ       (occ_s),
    .head      (out_data),
    .valid     (out_valid)
  );

  assign rden   = rden_s;
  assign rd_cnt = rd_cnt_r;
  assign busy   = (state_r == ST_DRAIN) | pending_r | (occ_s != {OCC_W{1'b0}});

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: a FIFO responder, a stream monitor and
// a queue-based expectation of the delivered word order and count.
module tb_fifo_rd_drain;

  localparam int WIDTH = 8;
  localparam int PTR   = 4;

  logic             rdclk = 1'b0;
  logic             reset = 1'b0;
  logic             rden;
  logic [WIDTH-1:0] dataout = 8'h00;
  logic             rdempty = 1'b1;
  logic [PTR:0]     rdusedw = 5'd0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      rd_cnt;
  logic             busy;

  logic [7:0] fmem [0:511];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_take = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         outst = 0;
  int         over_cnt = 0;
  int         acc_total = 0;
  int         model_cnt = 0;
  int         total = 0;
  int         bad = 0;

  fifo_rd_drain #(.WIDTH(WIDTH), .PTR(PTR), .THRESH(4), .BURST(16)) dut (
    .rdclk     (rdclk),
    .reset     (reset),
    .rden      (rden),
    .dataout   (dataout),
    .rdempty   (rdempty),
    .rdusedw   (rdusedw),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_cnt    (rd_cnt),
    .busy      (busy)
  );

  always #5 rdclk = ~rdclk;

  // FIFO responder: one-cycle read latency; written words become visible an edge later.
  always @(posedge rdclk) begin
    if (fifo_take) begin
      dataout <= fmem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
    rdempty <= (wr_ptr == rd_ptr + int'(fifo_take));
    rdusedw <= 5'(wr_ptr - rd_ptr - int'(fifo_take));
  end

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  always @(negedge rdclk) begin
    if (reset) begin
      fifo_take <= 1'b0;
      outst     <= 0;
    end else begin
      fifo_take <= rden & ~rdempty;
      if (rden && !rdempty) acc_total <= acc_total + 1;
      if (out_valid && out_ready) got.push_back(out_data);
      outst <= outst + int'(rden & ~rdempty) - int'(out_valid & out_ready);
      if (outst + int'(rden & ~rdempty) - int'(out_valid & out_ready) > 2)
        over_cnt <= over_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rdclk);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
    model_cnt = model_cnt + 1;
  endtask

  task automatic wait_done(input int gb, input int eb, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if ((got.size() - gb) >= (exp_q.size() - eb) && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    total++; if (rden !== 1'b0) begin bad++; $display("FAIL rst_rden got=%0b exp=0", rden); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%02h exp=00", out_data); end
    total++; if (rd_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", rd_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    reset = 1'b0;
    tick(3);
    total++; if (rden !== 1'b0) begin bad++; $display("FAIL rst_idle_rden got=%0b exp=0", rden); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_threshold;
    int gb, eb, a0, n;
    bit ok, seen;
    gb = got.size(); eb = exp_q.size(); a0 = acc_total;
    out_ready = 1'b1;
    load(8'h11); tick(1);
    load(8'h12); tick(1);
    load(8'h13); tick(4);
    total++; if (acc_total != a0) begin bad++; $display("FAIL thr_below_reads got=%0d exp=0", acc_total - a0); end
    total++; if (rden !== 1'b0) begin bad++; $display("FAIL thr_below_rden got=%0b exp=0", rden); end
    load(8'h14);
    tick(1);
    seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick(1);
      if (rden === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL thr_rden_start got=0 exp=1"); end
    wait_done(gb, eb, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL thr_timeout got=%0d words exp=%0d", got.size() - gb, exp_q.size() - eb); end
    n = exp_q.size() - eb;
    total++; if (got.size() - gb != n) begin bad++; $display("FAIL thr_count got=%0d exp=%0d", got.size() - gb, n); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (gb + i >= got.size()) begin bad++; $display("FAIL thr_word[%0d] got=none exp=%02h", i, exp_q[eb + i]); end
      else if (got[gb + i] !== exp_q[eb + i]) begin bad++; $display("FAIL thr_word[%0d] got=%02h exp=%02h", i, got[gb + i], exp_q[eb + i]); end
    end
    total++; if (rd_cnt !== 16'(model_cnt)) begin bad++; $display("FAIL thr_rd_cnt got=%0d exp=%0d", rd_cnt, model_cnt); end
  endtask

  task automatic test_throughput;
    int gb, eb, n;
    bit ok;
    logic expv;
    gb = got.size(); eb = exp_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) load(8'($urandom));
    tick(1);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      expv = ((k >= 3) && (k <= 18)) || (k == 20);
      if (k == 1) begin
        total++; if (rden !== 1'b1) begin bad++; $display("FAIL tp_rden_first got=%0b exp=1", rden); end
      end
      total++;
      if (out_valid !== expv) begin bad++; $display("FAIL tp_valid[k=%0d] got=%0b exp=%0b", k, out_valid, expv); end
    end
    wait_done(gb, eb, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL tp_timeout got=%0d words exp=%0d", got.size() - gb, exp_q.size() - eb); end
    n = exp_q.size() - eb;
    for (int i = 0; i < n; i++) begin
      total++;
      if (gb + i >= got.size()) begin bad++; $display("FAIL tp_word[%0d] got=none exp=%02h", i, exp_q[eb + i]); end
      else if (got[gb + i] !== exp_q[eb + i]) begin bad++; $display("FAIL tp_word[%0d] got=%02h exp=%02h", i, got[gb + i], exp_q[eb + i]); end
    end
    total++; if (rd_cnt !== 16'(model_cnt)) begin bad++; $display("FAIL tp_rd_cnt got=%0d exp=%0d", rd_cnt, model_cnt); end
  endtask

  task automatic test_backpressure;
    int gb, eb, n, oc0;
    bit ok;
    gb = got.size(); eb = exp_q.size(); oc0 = over_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) load(8'($urandom));
    tick($urandom_range(3, 5));
    out_ready = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick(1);
      if (j >= 3) begin
        total++; if (rden !== 1'b0) begin bad++; $display("FAIL bp_rden_stall[%0d] got=%0b exp=0", j, rden); end
      end
    end
    total++; if (outst != 2) begin bad++; $display("FAIL bp_outstanding got=%0d exp=2", outst); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%0b exp=1", busy); end
    out_ready = 1'b1;
    wait_done(gb, eb, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d words exp=%0d", got.size() - gb, exp_q.size() - eb); end
    total++; if (over_cnt != oc0) begin bad++; $display("FAIL bp_overflow got=%0d exp=0", over_cnt - oc0); end
    n = exp_q.size() - eb;
    for (int i = 0; i < n; i++) begin
      total++;
      if (gb + i >= got.size()) begin bad++; $display("FAIL bp_word[%0d] got=none exp=%02h", i, exp_q[eb + i]); end
      else if (got[gb + i] !== exp_q[eb + i]) begin bad++; $display("FAIL bp_word[%0d] got=%02h exp=%02h", i, got[gb + i], exp_q[eb + i]); end
    end
  endtask

  task automatic test_flush_idle_empty;
    int a0;
    a0 = acc_total;
    flush = 1'b1;
    tick(4);
    total++; if (rden !== 1'b0 || acc_total != a0) begin bad++; $display("FAIL fie_rden got=%0b exp=0", rden); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fie_busy got=%0b exp=0", busy); end
    flush = 1'b0;
    tick(1);
  endtask

  task automatic test_flush;
    int gb;
    bit seen;
    gb = got.size();
    out_ready = 1'b1;
    load(8'hA5);
    flush = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL fl_valid_timeout got=0 exp=1"); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL fl_data got=%02h exp=a5", out_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fl_busy_hold got=%0b exp=1", busy); end
    flush = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fl_busy_fall got=%0b exp=0", busy); end
    total++; if (got.size() != gb + 1) begin bad++; $display("FAIL fl_count got=%0d exp=1", got.size() - gb); end
    else if (got[gb] !== 8'hA5) begin bad++; $display("FAIL fl_word got=%02h exp=a5", got[gb]); end
    total++; if (rd_cnt !== 16'(model_cnt)) begin bad++; $display("FAIL fl_rd_cnt got=%0d exp=%0d", rd_cnt, model_cnt); end
  endtask

  task automatic test_random;
    int gb, eb, n, nw;
    bit ok, done;
    for (int it = 0; it < 6; it++) begin
      gb = got.size(); eb = exp_q.size();
      nw = $urandom_range(1, 12);
      for (int i = 0; i < nw; i++) load(8'($urandom));
      flush = (nw < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      done = 1'b0;
      for (int c = 0; c < 300; c++) begin
        if (got.size() - gb >= nw) begin
          done = 1'b1;
          break;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
      flush = 1'b0;
      out_ready = 1'b1;
      wait_done(gb, eb, 40, ok);
      total++; if (!(done && ok)) begin bad++; $display("FAIL rnd_timeout[%0d] got=%0d words exp=%0d", it, got.size() - gb, nw); end
      n = exp_q.size() - eb;
      for (int i = 0; i < n; i++) begin
        total++;
        if (gb + i >= got.size()) begin bad++; $display("FAIL rnd_word[%0d][%0d] got=none exp=%02h", it, i, exp_q[eb + i]); end
        else if (got[gb + i] !== exp_q[eb + i]) begin bad++; $display("FAIL rnd_word[%0d][%0d] got=%02h exp=%02h", it, i, got[gb + i], exp_q[eb + i]); end
      end
      total++; if (rd_cnt !== 16'(model_cnt)) begin bad++; $display("FAIL rnd_rd_cnt[%0d] got=%0d exp=%0d", it, rd_cnt, model_cnt); end
    end
    total++; if (over_cnt != 0) begin bad++; $display("FAIL rnd_overflow got=%0d exp=0", over_cnt); end
  endtask

  task automatic test_reset_mid_burst;
    int gb, eb, n;
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(8'($urandom));
    tick(6);
    total++; if (outst != 2) begin bad++; $display("FAIL rmb_pre_outstanding got=%0d exp=2", outst); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmb_pre_valid got=%0b exp=1", out_valid); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmb_valid got=%0b exp=0", out_valid); end
    total++; if (rd_cnt !== 16'd0) begin bad++; $display("FAIL rmb_cnt got=%0d exp=0", rd_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmb_busy got=%0b exp=0", busy); end
    total++; if (rden !== 1'b0) begin bad++; $display("FAIL rmb_rden got=%0b exp=0", rden); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rmb_data got=%02h exp=00", out_data); end
    // Accepted words are lost; only what is still inside the FIFO will come out.
    gb = got.size(); eb = exp_q.size();
    model_cnt = 0;
    for (int i = rd_ptr; i < wr_ptr; i++) begin
      exp_q.push_back(fmem[i]);
      model_cnt = model_cnt + 1;
    end
    @(posedge rdclk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    wait_done(gb, eb, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmb_timeout got=%0d words exp=%0d", got.size() - gb, exp_q.size() - eb); end
    n = exp_q.size() - eb;
    total++; if (got.size() - gb != n) begin bad++; $display("FAIL rmb_count got=%0d exp=%0d", got.size() - gb, n); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (gb + i >= got.size()) begin bad++; $display("FAIL rmb_word[%0d] got=none exp=%02h", i, exp_q[eb + i]); end
      else if (got[gb + i] !== exp_q[eb + i]) begin bad++; $display("FAIL rmb_word[%0d] got=%02h exp=%02h", i, got[gb + i], exp_q[eb + i]); end
    end
    total++; if (rd_cnt !== 16'(model_cnt)) begin bad++; $display("FAIL rmb_rd_cnt got=%0d exp=%0d", rd_cnt, model_cnt); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_throughput();
    test_backpressure();
    test_flush_idle_empty();
    test_flush();
    test_random();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
